ult_sar_search: RTL and testbench
=================================

Name: ult_sar_search

Overview:
- Successive-approximation controller. Drives the candidate operand of an external unsigned less-than comparator and recovers the comparator's hidden operand X, one bit per trial, MSB first.
- The comparator is wired with I0 = X and I1 = CAND, and returns LT = (X < CAND).
- Used on the icestick designs to digitise a value visible only through a compare result, e.g. threshold/DAC loops and comparator self-test.

Parameters:
- WIDTH, 8, bit width of CAND, RESULT and the searched value X (2..16).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a new search; sampled only while BUSY=0.
- LT  input  1  comparator result, 1 when X < CAND; combinational from CAND.
- CAND  output  WIDTH  trial value presented to the comparator I1 input.
- BUSY  output  1  high while a search is in progress.
- DONE  output  1  one-cycle pulse when RESULT is updated.
- RESULT  output  WIDTH  last completed search value; held until the next completion.

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RESET); all state updates on the rising CLK edge.
- Reset values: state=IDLE, CAND=0, BUSY=0, DONE=0, RESULT=0, bit index=WIDTH-1.
- States:
  - IDLE: BUSY=0, DONE=0. If START=1, next cycle: CAND = 1<<(WIDTH-1), index = WIDTH-1, go to TRIAL.
  - TRIAL: BUSY=1. Each cycle, sample LT against the current CAND.
    - If LT=1, clear CAND[index].
    - If index > 0, set CAND[index-1] and decrement index.
    - If index == 0, load RESULT with the final CAND (bit 0 cleared when LT=1), then go to DONE.
  - DONE: DONE=1 and BUSY=0 for exactly one cycle; CAND holds the final value. START=1 in this cycle is accepted (back-to-back search: next cycle is TRIAL with CAND = 1<<(WIDTH-1)). Otherwise go to IDLE.
- Latency: START accepted at cycle 0; trials occupy cycles 1..WIDTH; DONE=1 and RESULT valid at cycle WIDTH+1.
- Result rule: RESULT = X exactly for every X in 0..2^WIDTH-1. A bit is kept iff X >= trial value.
- START while BUSY=1 is ignored and never queued.
- RESET asserted mid-search aborts immediately to the reset values. RESULT is cleared to 0; no DONE pulse is issued.
- LT is don't-care in IDLE and DONE.
- CAND changes only on clock edges, so the comparator sees a stable operand for the whole cycle.

Optional Feature:
- Macro ULT_SAR_SEARCH_SETTLE_EN.
- Defined: a SETTLE state is inserted before every TRIAL sample. After CAND is updated, the block waits one cycle with BUSY=1 before sampling LT. This supports a registered comparator.
  - Latency becomes 2*WIDTH+1 from START acceptance to DONE.
  - RESET and START rules are unchanged.
- Undefined: no SETTLE state; latency is WIDTH+1 as above.

Test Plan:
- WIDTH=8, X=0x00 (bench models LT = X<CAND), START at cycle 0 -> CAND 0x80,0x40,0x20,0x10,0x08,0x04,0x02,0x01 on cycles 1..8; DONE=1 and RESULT=0x00 at cycle 9; BUSY high cycles 1..8.
- X=0xFF -> CAND 0x80,0xC0,0xE0,0xF0,0xF8,0xFC,0xFE,0xFF; RESULT=0xFF at cycle 9.
- X=0xA5 -> RESULT=0xA5 with DONE a single-cycle pulse. X=0x5A searched back-to-back via START held during the DONE cycle -> RESULT=0x5A exactly 9 cycles later.
- X=0x33, extra START pulses at cycles 3 and 5 -> ignored; RESULT=0x33 at cycle 9; only one DONE pulse.
- X=0x77, RESET at cycle 4 -> next cycle BUSY=0, CAND=0, RESULT=0, no DONE. A new START at cycle 7 -> RESULT=0x77 at cycle 16.
- With ULT_SAR_SEARCH_SETTLE_EN and X=0x3C, START at cycle 0 -> DONE at cycle 17, RESULT=0x3C; each CAND value is held 2 cycles.

Source files
------------

// File: rtl/ult_sar_search.sv
// Successive-approximation search of a hidden operand X through an external X < CAND comparator.
// Optional macro ULT_SAR_SEARCH_SETTLE_EN adds a settle cycle before every LT sample.
module ult_sar_search #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             LT,
  output logic [WIDTH-1:0] CAND,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0]  IdxTop  = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CandTop = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StTrial,
    StSettle,
    StDone
  } state_e;

`ifdef ULT_SAR_SEARCH_SETTLE_EN
  // Every new CAND value is held one extra cycle for a registered comparator.
  localparam state_e StAfterLoad = StSettle;
`else
  localparam state_e StAfterLoad = StTrial;
`endif

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] trial_cand;

  // Resolve the current bit from LT, then raise the next lower bit for its trial.
  always_comb begin
    trial_cand = cand_q;
    if (LT) begin
      trial_cand[idx_q] = 1'b0;
    end
    if (idx_q != '0) begin
      trial_cand[idx_q - IdxW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      idx_q    <= IdxTop;
      cand_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (START) begin
            cand_q  <= CandTop;
            idx_q   <= IdxTop;
            busy_q  <= 1'b1;
            state_q <= StAfterLoad;
          end
        end
        StSettle: begin
          state_q <= StTrial;
        end
        StTrial: begin
          cand_q <= trial_cand;
          if (idx_q != '0) begin
            idx_q   <= idx_q - IdxW'(1);
            state_q <= StAfterLoad;
          end else begin
            result_q <= trial_cand;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q <= 1'b0;
          if (START) begin
            cand_q  <= CandTop;
            idx_q   <= IdxTop;
            busy_q  <= 1'b1;
            state_q <= StAfterLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CAND   = cand_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_ult_sar_search.sv
// Directed bench for ult_sar_search: the comparator is modelled as LT = (x < CAND).
module tb_ult_sar_search;

  localparam int W = 8;
`ifdef ULT_SAR_SEARCH_SETTLE_EN
  localparam int Lat  = 2 * W + 1;
  localparam int Hold = 2;
`else
  localparam int Lat  = W + 1;
  localparam int Hold = 1;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic         LT;
  logic [W-1:0] x;
  logic [W-1:0] CAND;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived CAND sequence for X = 0x3C.
  logic [7:0] trace_3c [8] = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3D};

  ult_sar_search #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .LT    (LT),
    .CAND  (CAND),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .RESULT(RESULT)
  );

  assign LT = (x < CAND);

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // X = 0 walks a single one down; X = all-ones accumulates a prefix of ones.
  task automatic trace(input logic [W-1:0] xv, input bit ones);
    logic [W-1:0] ones_v;
    logic [W-1:0] top_v;
    logic [W-1:0] exp_c;
    int t;
    ones_v = '1;
    top_v  = {1'b1, {(W - 1){1'b0}}};
    x = xv;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 1; k < Lat; k++) begin
      t = (k - 1) / Hold;
      exp_c = ones ? (ones_v << (W - 1 - t)) : (top_v >> t);
      check("trace_cand", 32'(CAND), 32'(exp_c));
      check("trace_busy", 32'(BUSY), 32'd1);
      check("trace_done_low", 32'(DONE), 32'd0);
      step();
    end
    check("trace_done", 32'(DONE), 32'd1);
    check("trace_busy_low", 32'(BUSY), 32'd0);
    check("trace_result", 32'(RESULT), 32'(xv));
    check("trace_cand_final", 32'(CAND), 32'(xv));
    step();
  endtask

  initial begin
    int dones;
    RESET = 1'b1;
    START = 1'b0;
    x     = '0;
    step();
    step();
    check("rst_cand", 32'(CAND), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    RESET = 1'b0;
    step();

    trace(8'h00, 1'b0);
    trace(8'hFF, 1'b1);

    // Mid-value trace, each CAND held Hold cycles.
    x = 8'h3C;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 1; k < Lat; k++) begin
      check("x3c_cand", 32'(CAND), 32'(trace_3c[(k - 1) / Hold]));
      step();
    end
    check("x3c_done", 32'(DONE), 32'd1);
    check("x3c_result", 32'(RESULT), 32'h3C);
    step();

    // Back-to-back: START held during the DONE cycle.
    x = 8'hA5;
    START = 1'b1;
    step();
    START = 1'b0;
    dones = 0;
    for (int k = 1; k < Lat; k++) begin
      dones += int'(DONE);
      step();
    end
    check("a5_early_done", 32'(dones), 32'd0);
    check("a5_done", 32'(DONE), 32'd1);
    check("a5_result", 32'(RESULT), 32'hA5);
    x = 8'h5A;
    START = 1'b1;
    step();
    START = 1'b0;
    check("a5_pulse", 32'(DONE), 32'd0);
    check("b2b_busy", 32'(BUSY), 32'd1);
    check("b2b_cand", 32'(CAND), 32'h80);
    dones = 0;
    for (int k = 1; k < Lat; k++) begin
      dones += int'(DONE);
      if (k == Lat - 1) check("b2b_result_hold", 32'(RESULT), 32'hA5);
      step();
    end
    check("b2b_early_done", 32'(dones), 32'd0);
    check("5a_done", 32'(DONE), 32'd1);
    check("5a_result", 32'(RESULT), 32'h5A);
    step();
    check("5a_pulse", 32'(DONE), 32'd0);
    step();

    // START pulses while busy are ignored.
    x = 8'h33;
    START = 1'b1;
    step();
    START = 1'b0;
    dones = 0;
    for (int k = 1; k <= Lat + 3; k++) begin
      START = (k == 3 || k == 5);
      dones += int'(DONE);
      if (k == Lat) begin
        check("33_done", 32'(DONE), 32'd1);
        check("33_result", 32'(RESULT), 32'h33);
      end
      step();
    end
    START = 1'b0;
    check("33_one_done", 32'(dones), 32'd1);
    check("33_idle", 32'(BUSY), 32'd0);

    // RESET mid-search aborts and clears RESULT.
    x = 8'h77;
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_cand", 32'(CAND), 32'd0);
    check("abort_result", 32'(RESULT), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    step();
    check("abort_idle_done", 32'(DONE), 32'd0);
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    dones = 0;
    for (int k = 1; k < Lat; k++) begin
      dones += int'(DONE);
      step();
    end
    check("77_early_done", 32'(dones), 32'd0);
    check("77_done", 32'(DONE), 32'd1);
    check("77_result", 32'(RESULT), 32'h77);
    step();
    check("77_pulse", 32'(DONE), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
